// File: rtl/lc3b_branch_predictor_if.sv
// Fetch-side lookup, ID/EX training port and statistics of the LC-3b branch predictor.
// master drives fetch/update (pipeline side); slave is the predictor itself.
`timescale 1ns/1ps

interface lc3b_branch_predictor_if;
    logic [15:0] fetch_pc;
    logic [3:0]  fetch_opcode;
    logic        prediction;
    logic [15:0] pred_target;
    logic        update_valid;
    logic [15:0] update_pc;
    logic        update_taken;
    logic [15:0] update_target;
    logic        update_pred;
    logic [15:0] br_count;
    logic [15:0] mispredict_count;

    modport master (
        output fetch_pc,
        output fetch_opcode,
        input  prediction,
        input  pred_target,
        output update_valid,
        output update_pc,
        output update_taken,
        output update_target,
        output update_pred,
        input  br_count,
        input  mispredict_count
    );

    modport slave (
        input  fetch_pc,
        input  fetch_opcode,
        output prediction,
        output pred_target,
        input  update_valid,
        input  update_pc,
        input  update_taken,
        input  update_target,
        input  update_pred,
        output br_count,
        output mispredict_count
    );
endinterface

// File: rtl/lc3b_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, combinational
// fetch lookup, 1-cycle training from ID/EX, and saturating branch/mispredict counts.
`timescale 1ns/1ps

module lc3b_branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    lc3b_branch_predictor_if.slave   bp
);

    localparam int         ENTRIES  = 1 << INDEX_BITS;
    localparam int         TAG_BITS = 15 - INDEX_BITS;
    localparam logic [3:0] OP_BR    = 4'b0000;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        logic [1:0] r;
        if (c == 2'b11) begin
            r = 2'b11;
        end else begin
            r = c + 2'b01;
        end
        return r;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        logic [1:0] r;
        if (c == 2'b00) begin
            r = 2'b00;
        end else begin
            r = c - 2'b01;
        end
        return r;
    endfunction

    function automatic logic [15:0] cnt_inc(input logic [15:0] c);
        logic [15:0] r;
        if (c == 16'hFFFF) begin
            r = 16'hFFFF;
        end else begin
            r = c + 16'h0001;
        end
        return r;
    endfunction

    logic                  valid_r  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_r    [ENTRIES];
    logic [1:0]            ctr_r    [ENTRIES];
    logic [15:0]           target_r [ENTRIES];
    logic [15:0]           br_count_r;
    logic [15:0]           mispredict_count_r;

    logic [INDEX_BITS-1:0] fetch_idx_s;
    logic [TAG_BITS-1:0]   fetch_tag_s;
    logic                  fetch_hit_s;
    logic                  prediction_s;
    logic [15:0]           pred_target_s;

    logic [INDEX_BITS-1:0] upd_idx_s;
    logic [TAG_BITS-1:0]   upd_tag_s;
    logic                  upd_hit_s;
    logic                  upd_write_s;
    logic [1:0]            upd_ctr_s;
    logic [15:0]           upd_target_s;
    logic                  upd_mispredict_s;

    // Word-aligned PCs never use bit 0 for index or tag.
    logic                  unused_pc_bits_s;
    assign unused_pc_bits_s = bp.fetch_pc[0] ^ bp.update_pc[0];

    // Fetch lookup: purely combinational, reads pre-update state (no bypass).
    always_comb begin
        fetch_idx_s   = bp.fetch_pc[INDEX_BITS:1];
        fetch_tag_s   = bp.fetch_pc[15:INDEX_BITS+1];
        fetch_hit_s   = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
        prediction_s  = 1'b0;
        pred_target_s = 16'h0000;
        if ((bp.fetch_opcode == OP_BR) && fetch_hit_s && ctr_r[fetch_idx_s][1]) begin
            prediction_s  = 1'b1;
            pred_target_s = target_r[fetch_idx_s];
        end else begin
            prediction_s  = 1'b0;
            pred_target_s = 16'h0000;
        end
    end

    // Training decision: hit trains the counter, taken miss allocates, not-taken miss is dropped.
    always_comb begin
        upd_idx_s        = bp.update_pc[INDEX_BITS:1];
        upd_tag_s        = bp.update_pc[15:INDEX_BITS+1];
        upd_hit_s        = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
        upd_write_s      = 1'b0;
        upd_ctr_s        = ctr_r[upd_idx_s];
        upd_target_s     = target_r[upd_idx_s];
        upd_mispredict_s = bp.update_pred ^ bp.update_taken;
        if (upd_hit_s) begin
            upd_write_s = 1'b1;
            if (bp.update_taken) begin
                upd_ctr_s    = ctr_inc(ctr_r[upd_idx_s]);
                upd_target_s = bp.update_target;
            end else begin
                upd_ctr_s    = ctr_dec(ctr_r[upd_idx_s]);
                upd_target_s = target_r[upd_idx_s];
            end
        end else if (bp.update_taken) begin
            upd_write_s  = 1'b1;
            upd_ctr_s    = 2'b10;
            upd_target_s = bp.update_target;
        end else begin
            upd_write_s  = 1'b0;
        end
    end

    // Table storage; reset wins over a concurrent update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                ctr_r[i]    <= 2'b01;
                target_r[i] <= 16'h0000;
            end
        end else if (bp.update_valid && upd_write_s) begin
            valid_r[upd_idx_s]  <= 1'b1;
            tag_r[upd_idx_s]    <= upd_tag_s;
            ctr_r[upd_idx_s]    <= upd_ctr_s;
            target_r[upd_idx_s] <= upd_target_s;
        end else begin
            valid_r[upd_idx_s]  <= valid_r[upd_idx_s];
        end
    end

    // Saturating resolution statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_r         <= 16'h0000;
            mispredict_count_r <= 16'h0000;
        end else if (bp.update_valid) begin
            br_count_r <= cnt_inc(br_count_r);
            if (upd_mispredict_s) begin
                mispredict_count_r <= cnt_inc(mispredict_count_r);
            end else begin
                mispredict_count_r <= mispredict_count_r;
            end
        end else begin
            br_count_r         <= br_count_r;
            mispredict_count_r <= mispredict_count_r;
        end
    end

    assign bp.prediction       = prediction_s;
    assign bp.pred_target      = pred_target_s;
    assign bp.br_count         = br_count_r;
    assign bp.mispredict_count = mispredict_count_r;

    lc3b_branch_predictor_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .fetch_opcode (bp.fetch_opcode),
        .prediction   (prediction_s),
        .pred_target  (pred_target_s)
    );

endmodule

// Output-consistency checks: only BR opcodes predict, and a zero target accompanies no prediction.
module lc3b_branch_predictor_chk (
    input logic        clk,
    input logic        reset,
    input logic [3:0]  fetch_opcode,
    input logic        prediction,
    input logic [15:0] pred_target
);
    // Sampled once per cycle outside reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!prediction || (fetch_opcode == 4'b0000))
                else $error("predictor chk: prediction on non-BR opcode %h", fetch_opcode);
            assert (prediction || (pred_target == 16'h0000))
                else $error("predictor chk: nonzero target %h without prediction", pred_target);
        end
    end
endmodule

// File: tb/tb_lc3b_branch_predictor.sv
// Directed scoreboard bench for lc3b_branch_predictor: expectations are queued when a
// step is driven and popped/compared at the following negative clock edge.
`timescale 1ns/1ps

module tb_lc3b_branch_predictor;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;

    typedef struct {
        string       tag;
        logic        prediction;
        logic [15:0] pred_target;
        logic [15:0] br_count;
        logic [15:0] mispredict_count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic [15:0] exp_br = 16'h0000;
    logic [15:0] exp_mp = 16'h0000;

    lc3b_branch_predictor_if bp_if ();

    lc3b_branch_predictor #(.INDEX_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [15:0] fpc, input logic [3:0] fop,
                         input logic uv, input logic [15:0] upc, input logic tk,
                         input logic [15:0] tgt, input logic upred);
        reset                  = rst;
        bp_if.fetch_pc         = fpc;
        bp_if.fetch_opcode     = fop;
        bp_if.update_valid     = uv;
        bp_if.update_pc        = upc;
        bp_if.update_taken     = tk;
        bp_if.update_target    = tgt;
        bp_if.update_pred      = upred;
    endtask

    task automatic expect_out(input string tag, input logic p, input logic [15:0] t);
        exp_t e;
        e.tag              = tag;
        e.prediction       = p;
        e.pred_target      = t;
        e.br_count         = exp_br;
        e.mispredict_count = exp_mp;
        sb_q.push_back(e);
    endtask

    // Advance one clock; model the statistics from what was applied at the edge.
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            exp_br = 16'h0000;
            exp_mp = 16'h0000;
        end else if (bp_if.update_valid) begin
            if (exp_br != 16'hFFFF) exp_br = exp_br + 16'h0001;
            if ((bp_if.update_pred != bp_if.update_taken) && (exp_mp != 16'hFFFF))
                exp_mp = exp_mp + 16'h0001;
        end
        #1;
    endtask

    task automatic run_cycle();
        exp_t e;
        @(negedge clk);
        n_cmp++;
        assert (sb_q.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_pred"}, {15'h0000, bp_if.prediction}, {15'h0000, e.prediction});
            check({e.tag, "_tgt"},  bp_if.pred_target,      e.pred_target);
            check({e.tag, "_brc"},  bp_if.br_count,         e.br_count);
            check({e.tag, "_mpc"},  bp_if.mispredict_count, e.mispredict_count);
        end
        advance();
    endtask

    initial begin
        drive(1'b1, 16'h0000, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        advance();
        advance();

        // Reset state.
        drive(1'b0, 16'h0010, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("reset_lookup", 1'b0, 16'h0000); run_cycle();

        // Taken allocate; same-cycle lookup still sees the empty entry.
        drive(1'b0, 16'h0010, OP_BR, 1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0);
        expect_out("alloc_same_cycle", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("alloc_hit", 1'b1, 16'h0040); run_cycle();
        drive(1'b0, 16'h0010, OP_ADD, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("non_br_hit", 1'b0, 16'h0000); run_cycle();

        // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10.
        drive(1'b0, 16'h0010, OP_BR, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1);
        expect_out("nt1_old", 1'b1, 16'h0040); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
        expect_out("nt2_ctr01", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
        expect_out("nt3_ctr00", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b1, 16'h0010, 1'b1, 16'h0050, 1'b0);
        expect_out("tk_from00", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("ctr01_nopred", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b1, 16'h0010, 1'b1, 16'h0060, 1'b0);
        expect_out("tk_from01", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("ctr10_newtgt", 1'b1, 16'h0060); run_cycle();

        // Aliasing at index 8: not-taken miss must not replace; taken miss replaces.
        drive(1'b0, 16'h0010, OP_BR, 1'b1, 16'h0030, 1'b0, 16'h0100, 1'b1);
        expect_out("alias_nt_miss", 1'b1, 16'h0060); run_cycle();
        drive(1'b0, 16'h0030, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("alias_no_alloc", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("alias_orig_kept", 1'b1, 16'h0060); run_cycle();
        drive(1'b0, 16'h0030, OP_BR, 1'b1, 16'h0030, 1'b1, 16'h0100, 1'b0);
        expect_out("alias_tk_same_cycle", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("alias_orig_evicted", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0030, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("alias_new_hit", 1'b1, 16'h0100); run_cycle();
        drive(1'b0, 16'h0012, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("other_index_miss", 1'b0, 16'h0000); run_cycle();

        // Drive mispredicts (not-taken misses at index 1) until the count saturates.
        drive(1'b0, 16'h0030, OP_BR, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b1);
        while (exp_mp != 16'hFFFF) advance();
        expect_out("sat_reached", 1'b1, 16'h0100); run_cycle();
        drive(1'b0, 16'h0030, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("sat_held", 1'b1, 16'h0100); run_cycle();

        // Reset concurrent with a taken update: update discarded, state cleared.
        drive(1'b1, 16'h0030, OP_BR, 1'b1, 16'h0030, 1'b1, 16'h0200, 1'b0);
        expect_out("reset_with_update", 1'b1, 16'h0100); run_cycle();
        drive(1'b0, 16'h0030, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("post_reset_30", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0010, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("post_reset_10", 1'b0, 16'h0000); run_cycle();

        // Relearn after reset with a correct prediction.
        drive(1'b0, 16'h0030, OP_BR, 1'b1, 16'h0030, 1'b1, 16'h0300, 1'b1);
        expect_out("relearn_same_cycle", 1'b0, 16'h0000); run_cycle();
        drive(1'b0, 16'h0030, OP_BR, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        expect_out("relearn_hit", 1'b1, 16'h0300); run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
